// File: rtl/mport_arbiter.sv
// mport_arbiter: round-robin arbiter that lets NUM_PORTS cache-side
// requesters share one M9K block-RAM port and one SDRAM controller port.
//
// Ports
//   clk, rst_l          clock, asynchronous active-low reset
//   req_valid[p]        port p request, held until resp_done[p]
//   req_op[p]           00 r_one, 01 w_one, 10 r_line, 11 w_line
//   req_addr[p]         word address; MSB selects M9K (1) or SDRAM (0)
//   req_line_store[p]   write line (word 0 used by single ops)
//   resp_line_read      shared read line, valid while resp_done pulses
//   resp_done[p]        one-cycle completion pulse to the granted port
//   SDRAM_*             SDRAM controller side (beat-serialised words)
//   m9k_*               M9K side (one 32-bit word per access)
//   fsm_state           current arbiter state, for observation only
//
// Handshakes: a requester raises req_valid and holds it and its op,
// address and data stable until it sees resp_done; the arbiter latches
// everything at grant, so a requester that drops early is still served.
// On the memory sides the arbiter holds its strobe, address and data until
// the memory returns a one-cycle done; SDRAM_as is only asserted while
// SDRAM_ready is high, and is dropped for one cycle after every done.
module mport_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_SIZE  = 24,
  parameter int SDRAM_DW   = 16,
  parameter int SDRAM_AW   = 23
) (
  input  logic                               clk,
  input  logic                               rst_l,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS*2-1:0]             req_op,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0]     req_addr,
  input  logic [NUM_PORTS*LINE_WORDS*32-1:0] req_line_store,
  output logic [LINE_WORDS*32-1:0]           resp_line_read,
  output logic [NUM_PORTS-1:0]               resp_done,
  output logic                               SDRAM_pll_locked,
  input  logic                               SDRAM_ready,
  output logic                               SDRAM_as,
  output logic                               SDRAM_rw,
  output logic [SDRAM_AW-1:0]                SDRAM_addr,
  output logic [SDRAM_DW-1:0]                SDRAM_data_write,
  input  logic [SDRAM_DW-1:0]                SDRAM_data_read,
  input  logic                               SDRAM_done,
  output logic                               m9k_w_en,
  output logic                               m9k_r_en,
  output logic [14:0]                        m9k_addr,
  output logic [31:0]                        m9k_data_store,
  input  logic [31:0]                        m9k_data_load,
  input  logic                               m9k_done,
  output logic [2:0]                         fsm_state
);

  localparam int BEATS = 32 / SDRAM_DW;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WI    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CW    = $clog2(LINE_WORDS + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    M9K_REQ   = 3'd2,
    SDRAM_REQ = 3'd3,
    SDRAM_GAP = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t                    state;
  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             gnt_port;
  logic [1:0]                cur_op;
  logic [ADDR_SIZE-1:0]      cur_addr;
  logic [LINE_WORDS*32-1:0]  store_q;
  logic [CW-1:0]             word_ctr;
  logic [CW-1:0]             count;
  logic [BW-1:0]             beat_ctr;

  // Round-robin pick: scan from rr_ptr upward, wrapping, first valid wins.
  int                        cand;
  logic                      pick_found;
  logic [PW-1:0]             pick_port;
  logic [PW-1:0]             rr_next;
  logic [1:0]                sel_op;
  logic [ADDR_SIZE-1:0]      sel_addr;
  logic [LINE_WORDS*32-1:0]  sel_store;

  always_comb begin
    cand       = 0;
    pick_found = 1'b0;
    pick_port  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!pick_found && req_valid[PW'(cand)]) begin
        pick_found = 1'b1;
        pick_port  = PW'(cand);
      end
    end
  end

  assign rr_next   = (pick_port == PW'(NUM_PORTS - 1)) ? '0 : pick_port + PW'(1);
  assign sel_op    = req_op[pick_port*2 +: 2];
  assign sel_addr  = req_addr[pick_port*ADDR_SIZE +: ADDR_SIZE];
  assign sel_store = req_line_store[pick_port*LINE_WORDS*32 +: LINE_WORDS*32];

  // Current word: line base (already aligned at grant) plus word index.
  logic [ADDR_SIZE-1:0] word_addr;
  logic [WI-1:0]        word_idx;
  logic [31:0]          store_word;

  assign word_addr  = cur_addr + ADDR_SIZE'(word_ctr);
  assign word_idx   = word_ctr[WI-1:0];
  assign store_word = store_q[word_idx*32 +: 32];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      gnt_port       <= '0;
      cur_op         <= '0;
      cur_addr       <= '0;
      store_q        <= '0;
      word_ctr       <= '0;
      count          <= '0;
      beat_ctr       <= '0;
      resp_line_read <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt_port <= pick_port;
            rr_ptr   <= rr_next;
            cur_op   <= sel_op;
            // Line ops always start at the line-aligned base address.
            cur_addr <= sel_op[1] ? (sel_addr & LINE_MASK) : sel_addr;
            store_q  <= sel_store;
            state    <= GRANT;
          end
        end
        GRANT: begin
          word_ctr <= '0;
          beat_ctr <= '0;
          count    <= cur_op[1] ? CW'(LINE_WORDS) : CW'(1);
          state    <= cur_addr[ADDR_SIZE-1] ? M9K_REQ : SDRAM_REQ;
        end
        M9K_REQ: begin
          if (m9k_done) begin
            if (!cur_op[0]) resp_line_read[word_idx*32 +: 32] <= m9k_data_load;
            word_ctr <= word_ctr + CW'(1);
            if (word_ctr + CW'(1) == count) state <= RESP;
          end
        end
        SDRAM_REQ: begin
          if (SDRAM_done) begin
            if (!cur_op[0])
              resp_line_read[word_idx*32 + int'(beat_ctr)*SDRAM_DW +: SDRAM_DW] <= SDRAM_data_read;
            state <= SDRAM_GAP;
          end
        end
        SDRAM_GAP: begin
          // Address strobe is low here; advance to the next beat or word.
          if (beat_ctr == BW'(BEATS - 1)) begin
            beat_ctr <= '0;
            word_ctr <= word_ctr + CW'(1);
            state    <= (word_ctr + CW'(1) == count) ? RESP : SDRAM_REQ;
          end else begin
            beat_ctr <= beat_ctr + BW'(1);
            state    <= SDRAM_REQ;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are decoded from registered state and counters;
  // SDRAM_as additionally follows SDRAM_ready in the same cycle so the
  // controller never sees a strobe while it is not ready.
  always_comb begin
    resp_done        = '0;
    SDRAM_as         = 1'b0;
    SDRAM_rw         = 1'b0;
    SDRAM_addr       = '0;
    SDRAM_data_write = '0;
    m9k_w_en         = 1'b0;
    m9k_r_en         = 1'b0;
    m9k_addr         = '0;
    m9k_data_store   = '0;
    case (state)
      M9K_REQ: begin
        m9k_w_en = cur_op[0];
        m9k_r_en = !cur_op[0];
        m9k_addr = word_addr[14:0];
        if (cur_op[0]) m9k_data_store = store_word;
      end
      SDRAM_REQ: begin
        SDRAM_as   = SDRAM_ready;
        SDRAM_rw   = cur_op[0];
        // {word address, beat}, truncated to the SDRAM address width.
        SDRAM_addr = SDRAM_AW'(word_addr) * SDRAM_AW'(BEATS) + SDRAM_AW'(beat_ctr);
        if (cur_op[0]) SDRAM_data_write = store_word[int'(beat_ctr)*SDRAM_DW +: SDRAM_DW];
      end
      RESP: resp_done[gnt_port] = 1'b1;
      default: ;
    endcase
  end

  assign SDRAM_pll_locked = 1'b1;
  assign fsm_state        = state;

endmodule

// File: tb/tb_mport_arbiter.sv
// tb_mport_arbiter: directed bench for mport_arbiter (default parameters).
// Requests are driven per port; expected memory accesses and responses are
// queued as stimulus is issued and popped by a negedge monitor.
module tb_mport_arbiter;

  logic          clk = 1'b0;
  logic          rst_l;
  logic [1:0]    req_valid;
  logic [3:0]    req_op;
  logic [47:0]   req_addr;
  logic [255:0]  req_line_store;
  logic [127:0]  resp_line_read;
  logic [1:0]    resp_done;
  logic          SDRAM_pll_locked;
  logic          SDRAM_ready;
  logic          SDRAM_as;
  logic          SDRAM_rw;
  logic [22:0]   SDRAM_addr;
  logic [15:0]   SDRAM_data_write;
  logic [15:0]   SDRAM_data_read;
  logic          SDRAM_done;
  logic          m9k_w_en;
  logic          m9k_r_en;
  logic [14:0]   m9k_addr;
  logic [31:0]   m9k_data_store;
  logic [31:0]   m9k_data_load;
  logic          m9k_done;
  logic [2:0]    fsm_state;

  mport_arbiter dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_line_store(req_line_store),
    .resp_line_read(resp_line_read), .resp_done(resp_done),
    .SDRAM_pll_locked(SDRAM_pll_locked), .SDRAM_ready(SDRAM_ready),
    .SDRAM_as(SDRAM_as), .SDRAM_rw(SDRAM_rw), .SDRAM_addr(SDRAM_addr),
    .SDRAM_data_write(SDRAM_data_write), .SDRAM_data_read(SDRAM_data_read),
    .SDRAM_done(SDRAM_done),
    .m9k_w_en(m9k_w_en), .m9k_r_en(m9k_r_en), .m9k_addr(m9k_addr),
    .m9k_data_store(m9k_data_store), .m9k_data_load(m9k_data_load),
    .m9k_done(m9k_done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int sd_acc_cnt = 0;

  logic [47:0]  exp_m9k_q[$];   // {we, addr[14:0], data[31:0]}
  logic [39:0]  exp_sd_q[$];    // {rw, addr[22:0], data[15:0]}
  logic [129:0] exp_resp_q[$];  // {resp_done[1:0], line[127:0]}

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not reached", name);
  endtask

  task automatic exp_m9k(input logic we, input logic [14:0] a, input logic [31:0] d);
    exp_m9k_q.push_back({we, a, d});
  endtask

  task automatic exp_sd(input logic rw, input logic [22:0] a, input logic [15:0] d);
    exp_sd_q.push_back({rw, a, d});
  endtask

  task automatic exp_resp(input logic [1:0] dn, input logic [127:0] line);
    exp_resp_q.push_back({dn, line});
  endtask

  // ---------------- memory models ----------------
  logic [31:0] m9k_mem [0:32767];
  logic [15:0] sd_mem  [0:255];

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m9k_done       <= 1'b0;
      SDRAM_done     <= 1'b0;
      m9k_data_load  <= '0;
      SDRAM_data_read <= '0;
      m9k_mem[15'h10] <= 32'h0000_00A0;
      m9k_mem[15'h11] <= 32'h0000_00A1;
      m9k_mem[15'h12] <= 32'h0000_00A2;
      m9k_mem[15'h13] <= 32'h0000_00A3;
    end else begin
      if ((m9k_w_en || m9k_r_en) && !m9k_done) begin
        m9k_done      <= 1'b1;
        m9k_data_load <= m9k_mem[m9k_addr];
        if (m9k_w_en) m9k_mem[m9k_addr] <= m9k_data_store;
      end else begin
        m9k_done <= 1'b0;
      end
      if (SDRAM_as && !SDRAM_done) begin
        SDRAM_done      <= 1'b1;
        SDRAM_data_read <= sd_mem[SDRAM_addr[7:0]];
        if (SDRAM_rw) sd_mem[SDRAM_addr[7:0]] <= SDRAM_data_write;
      end else begin
        SDRAM_done <= 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic         prev_sd_done;
  logic [47:0]  me;
  logic [39:0]  se;
  logic [129:0] re;

  always @(negedge clk) begin
    if (!rst_l) begin
      prev_sd_done <= 1'b0;
    end else begin
      if (prev_sd_done) check("sd_gap_as_low", SDRAM_as, 0);
      prev_sd_done <= SDRAM_as && SDRAM_done;
      if (SDRAM_as) check("sd_as_needs_ready", SDRAM_ready, 1);
      if ((m9k_w_en || m9k_r_en) && !m9k_done) begin
        if (exp_m9k_q.size() == 0) fail("m9k_unexpected_access");
        else begin
          me = exp_m9k_q.pop_front();
          check("m9k_w_en", m9k_w_en, me[47]);
          check("m9k_r_en", m9k_r_en, !me[47]);
          check("m9k_addr", m9k_addr, me[46:32]);
          if (me[47]) check("m9k_data_store", m9k_data_store, me[31:0]);
        end
      end
      if (SDRAM_as && !SDRAM_done) begin
        sd_acc_cnt++;
        if (exp_sd_q.size() == 0) fail("sd_unexpected_access");
        else begin
          se = exp_sd_q.pop_front();
          check("sd_rw", SDRAM_rw, se[39]);
          check("sd_addr", SDRAM_addr, se[38:16]);
          if (se[39]) check("sd_data_write", SDRAM_data_write, se[15:0]);
        end
      end
      if (resp_done != 2'b00) begin
        if (exp_resp_q.size() == 0) fail("resp_unexpected");
        else begin
          re = exp_resp_q.pop_front();
          check("resp_done", resp_done, re[129:128]);
          check("resp_line_read", resp_line_read, re[127:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Caller is just past a negedge; request held until this port's resp_done.
  task automatic do_req(input int p, input logic [1:0] op, input logic [23:0] a,
                        input logic [127:0] line);
    bit got;
    got = 1'b0;
    req_op[p*2 +: 2]           = op;
    req_addr[p*24 +: 24]       = a;
    req_line_store[p*128 +: 128] = line;
    req_valid[p]               = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (resp_done[p]) got = 1'b1;
    end
    req_valid[p] = 1'b0;
    if (!got) fail("resp_timeout");
  endtask

  task automatic check_quiet_outputs();
    check("q_resp_done", resp_done, 0);
    check("q_sd_as", SDRAM_as, 0);
    check("q_sd_rw", SDRAM_rw, 0);
    check("q_sd_addr", SDRAM_addr, 0);
    check("q_sd_data", SDRAM_data_write, 0);
    check("q_m9k_w_en", m9k_w_en, 0);
    check("q_m9k_r_en", m9k_r_en, 0);
    check("q_m9k_addr", m9k_addr, 0);
    check("q_m9k_data", m9k_data_store, 0);
    check("q_pll_locked", SDRAM_pll_locked, 1);
    check("q_state_idle", fsm_state, 0);
  endtask

  logic [127:0] wline;
  int           base_cnt;
  bit           hit;

  initial begin
    rst_l          = 1'b0;
    req_valid      = '0;
    req_op         = '0;
    req_addr       = '0;
    req_line_store = '0;
    SDRAM_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet_outputs();
    check("rst_line_read", resp_line_read, 0);
    rst_l = 1'b1;
    @(negedge clk);
    check_quiet_outputs();

    // A: both ports in the same cycle from reset -> port0 then port1.
    exp_m9k(1'b1, 15'h0100, 32'h1111_2222);
    exp_m9k(1'b1, 15'h0200, 32'h3333_4444);
    exp_resp(2'b01, 128'h0);
    exp_resp(2'b10, 128'h0);
    fork
      do_req(0, 2'b01, 24'h800100, 128'h1111_2222);
      do_req(1, 2'b01, 24'h800200, 128'h3333_4444);
    join

    // B: port0 line read from M9K.
    exp_m9k(1'b0, 15'h0010, 32'h0);
    exp_m9k(1'b0, 15'h0011, 32'h0);
    exp_m9k(1'b0, 15'h0012, 32'h0);
    exp_m9k(1'b0, 15'h0013, 32'h0);
    exp_resp(2'b01, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);
    do_req(0, 2'b10, 24'h800010, 128'h0);

    // C: both again; rr pointer now at port1 -> port1 first. Single reads
    // only replace word 0.
    exp_m9k(1'b0, 15'h0200, 32'h0);
    exp_m9k(1'b0, 15'h0100, 32'h0);
    exp_resp(2'b10, 128'h0000_00A3_0000_00A2_0000_00A1_3333_4444);
    exp_resp(2'b01, 128'h0000_00A3_0000_00A2_0000_00A1_1111_2222);
    fork
      do_req(0, 2'b00, 24'h800100, 128'h0);
      do_req(1, 2'b00, 24'h800200, 128'h0);
    join

    // D: port1 single write to SDRAM, two beats with a gap between.
    exp_sd(1'b1, 23'h00000A, 16'hBEEF);
    exp_sd(1'b1, 23'h00000B, 16'hDEAD);
    exp_resp(2'b10, 128'h0000_00A3_0000_00A2_0000_00A1_1111_2222);
    do_req(1, 2'b01, 24'h000005, 128'hDEAD_BEEF);

    // E: read it back as a single read.
    exp_sd(1'b0, 23'h00000A, 16'h0);
    exp_sd(1'b0, 23'h00000B, 16'h0);
    exp_resp(2'b10, 128'h0000_00A3_0000_00A2_0000_00A1_DEAD_BEEF);
    do_req(1, 2'b00, 24'h000005, 128'h0);

    // F: line write to unaligned address with SDRAM_ready low for 10 cycles.
    wline = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    for (int k = 0; k < 8; k++) exp_sd(1'b1, 23'h40 + 23'(k), wline[k*16 +: 16]);
    exp_resp(2'b01, 128'h0000_00A3_0000_00A2_0000_00A1_DEAD_BEEF);
    SDRAM_ready = 1'b0;
    fork
      do_req(0, 2'b11, 24'h000023, wline);
      begin
        repeat (10) begin
          @(negedge clk);
          check("sd_as_low_not_ready", SDRAM_as, 0);
        end
        SDRAM_ready = 1'b1;
      end
    join

    // G: line read back from SDRAM.
    for (int k = 0; k < 8; k++) exp_sd(1'b0, 23'h40 + 23'(k), 16'h0);
    exp_resp(2'b10, wline);
    do_req(1, 2'b10, 24'h000021, 128'h0);

    // H: reset in the middle of an SDRAM line read.
    for (int k = 0; k < 8; k++) exp_sd(1'b0, 23'h60 + 23'(k), 16'h0);
    base_cnt     = sd_acc_cnt;
    req_op[1:0]  = 2'b10;
    req_addr[23:0] = 24'h000030;
    req_valid[0] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (sd_acc_cnt >= base_cnt + 3) hit = 1'b1;
    end
    if (!hit) fail("mid_read_not_reached");
    #2;
    rst_l = 1'b0;
    #1;
    check_quiet_outputs();
    check("rst_line_read_mid", resp_line_read, 0);
    req_valid = '0;
    exp_sd_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_no_resp_done", resp_done, 0);
    end
    rst_l = 1'b1;
    @(negedge clk);
    check("post_rst_state_idle", fsm_state, 0);
    check("post_rst_line_read", resp_line_read, 0);

    // I: fresh requests after reset.
    for (int k = 0; k < 8; k++) exp_sd(1'b0, 23'h40 + 23'(k), 16'h0);
    exp_resp(2'b01, wline);
    do_req(0, 2'b10, 24'h000020, 128'h0);
    exp_m9k(1'b0, 15'h0013, 32'h0);
    exp_resp(2'b10, 128'h7777_6666_5555_4444_3333_2222_0000_00A3);
    do_req(1, 2'b00, 24'h800013, 128'h0);

    repeat (5) @(negedge clk);
    check("m9k_queue_drained", exp_m9k_q.size(), 0);
    check("sd_queue_drained", exp_sd_q.size(), 0);
    check("resp_queue_drained", exp_resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
